spi_frame_arbiter: RTL and testbench

- System-clock-side controller for the serial SPI frame block. It shares the single full-duplex SPI frame stream among N_CH on-chip requesters.
- Receive path: synchronizes the frame-complete strobe, captures the received frame, decodes its channel header and routes the payload to the addressed requester.
- Transmit path: round-robin arbitrates pending requester payloads, builds the outgoing frame and holds it on the SPI block's parallel load input until that frame has been shifted out.

---
 rtl/spi_frame_arbiter_if.sv | 23 ++
 rtl/spi_frame_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_spi_frame_arbiter.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_frame_arbiter_if.sv
// Requester-side bundle of the SPI frame arbiter: per-channel transmit handshake
// plus the shared receive bus.
interface spi_frame_arbiter_if #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned PL   = 60
);
  logic [N_CH-1:0]    tx_valid;
  logic [N_CH*PL-1:0] tx_data;
  logic [N_CH-1:0]    tx_ready;
  logic [N_CH-1:0]    tx_done;
  logic [N_CH-1:0]    rx_valid;
  logic [PL-1:0]      rx_data;

  modport master (
    output tx_valid, tx_data,
    input  tx_ready, tx_done, rx_valid, rx_data
  );

  modport slave (
    input  tx_valid, tx_data,
    output tx_ready, tx_done, rx_valid, rx_data
  );
endinterface

// File: rtl/spi_frame_arbiter.sv
// System-clock controller sharing one full-duplex SPI frame stream among N_CH
// requesters: header-routed receive and round-robin arbitrated transmit.
module spi_frame_arbiter #(
  parameter int unsigned DATA_LENGTH = 64,
  parameter int unsigned N_CH        = 4,
  parameter int unsigned CH_BITS     = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_LENGTH-1:0] spi_data_in,
  input  logic                   spi_data_ready,
  input  logic                   spi_cs,
  output logic [DATA_LENGTH-1:0] spi_data_out,
  spi_frame_arbiter_if.slave     req,
  output logic                   busy,
  output logic [7:0]             bad_ch_cnt
);
  localparam int unsigned PL = DATA_LENGTH - CH_BITS;
  localparam logic [DATA_LENGTH-1:0] IDLE_FRAME = {{CH_BITS{1'b1}}, {PL{1'b0}}};
  localparam logic [CH_BITS-1:0] HDR_IDLE = {CH_BITS{1'b1}};
  localparam logic [CH_BITS-1:0] LAST_CH  = CH_BITS'(N_CH - 1);

  typedef enum logic {S_IDLE, S_STAGED} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] dr_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic                   dr_prev_q;
  logic                   frame_done;

  logic [CH_BITS-1:0]     ptr_q, ptr_c;
  logic [CH_BITS-1:0]     gch_q, gch_c;
  logic [DATA_LENGTH-1:0] data_out_q, data_out_c;
  logic [N_CH-1:0]        tx_ready_q, tx_ready_c;
  logic [N_CH-1:0]        tx_done_q, tx_done_c;
  logic                   busy_q, busy_c;

  logic [N_CH-1:0]        rx_valid_q;
  logic [PL-1:0]          rx_data_q;
  logic [7:0]             bad_q;
  logic [CH_BITS-1:0]     hdr;

  logic                   grant_any;
  logic [CH_BITS-1:0]     grant_idx;
  logic [PL-1:0]          grant_pl;

  // CDC: frame-complete flag and chip select; bit 0 is the newest sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dr_sync_q <= '0;
      cs_sync_q <= '1;
      dr_prev_q <= 1'b0;
    end else begin
      dr_sync_q <= (dr_sync_q << 1) | SYNC_STAGES'(spi_data_ready);
      cs_sync_q <= (cs_sync_q << 1) | SYNC_STAGES'(spi_cs);
      dr_prev_q <= dr_sync_q[SYNC_STAGES-1];
    end
  end

  assign frame_done = dr_sync_q[SYNC_STAGES-1] & ~dr_prev_q;

  // An aborted CS window needs no action: the staged frame is simply held for the next one.
  logic unused_cs;
  assign unused_cs = ^cs_sync_q;

  assign hdr = spi_data_in[DATA_LENGTH-1 -: CH_BITS];

  // Receive path: route by header, count out-of-range headers, ignore idle frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid_q <= '0;
      rx_data_q  <= '0;
      bad_q      <= '0;
    end else begin
      rx_valid_q <= '0;
      if (frame_done) begin
        if (hdr < CH_BITS'(N_CH)) begin
          rx_valid_q <= N_CH'(1) << hdr;
          rx_data_q  <= spi_data_in[PL-1:0];
        end else if (hdr != HDR_IDLE && bad_q != 8'hFF) begin
          bad_q <= bad_q + 8'd1;
        end
      end
    end
  end

  // Round-robin pick: lowest requester at/after the pointer, else lowest overall.
  always_comb begin
    logic               found_hi, found_lo;
    logic [CH_BITS-1:0] idx_hi, idx_lo;
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    grant_pl = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (!found_hi && req.tx_valid[i] && CH_BITS'(i) >= ptr_q) begin
        found_hi = 1'b1;
        idx_hi   = CH_BITS'(i);
      end
      if (!found_lo && req.tx_valid[i]) begin
        found_lo = 1'b1;
        idx_lo   = CH_BITS'(i);
      end
    end
    grant_any = found_lo;
    grant_idx = found_hi ? idx_hi : idx_lo;
    for (int i = 0; i < N_CH; i++) begin
      if (CH_BITS'(i) == grant_idx) grant_pl = req.tx_data[i*PL +: PL];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (grant_any)  state_d = S_STAGED;
      S_STAGED: if (frame_done) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_ready_c = '0;
    tx_done_c  = '0;
    data_out_c = data_out_q;
    ptr_c      = ptr_q;
    gch_c      = gch_q;
    busy_c     = (state_d == S_STAGED);
    case (state_q)
      S_IDLE: begin
        data_out_c = IDLE_FRAME;
        if (grant_any) begin
          tx_ready_c = N_CH'(1) << grant_idx;
          data_out_c = {grant_idx, grant_pl};
          gch_c      = grant_idx;
          ptr_c      = (grant_idx == LAST_CH) ? '0 : grant_idx + CH_BITS'(1);
        end
      end
      S_STAGED: begin
        if (frame_done) begin
          tx_done_c  = N_CH'(1) << gch_q;
          data_out_c = IDLE_FRAME;
        end
      end
      default: data_out_c = IDLE_FRAME;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      gch_q      <= '0;
      data_out_q <= IDLE_FRAME;
      tx_ready_q <= '0;
      tx_done_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      ptr_q      <= ptr_c;
      gch_q      <= gch_c;
      data_out_q <= data_out_c;
      tx_ready_q <= tx_ready_c;
      tx_done_q  <= tx_done_c;
      busy_q     <= busy_c;
    end
  end

  assign spi_data_out = data_out_q;
  assign busy         = busy_q;
  assign bad_ch_cnt   = bad_q;
  assign req.tx_ready = tx_ready_q;
  assign req.tx_done  = tx_done_q;
  assign req.rx_valid = rx_valid_q;
  assign req.rx_data  = rx_data_q;
endmodule

// File: tb/tb_spi_frame_arbiter.sv
// Scoreboard bench for spi_frame_arbiter: a driver issues requests and SPI frames
// and queues expected responses; a monitor pops and compares whatever the DUT presents.
module tb_spi_frame_arbiter;
  localparam int unsigned DL      = 64;
  localparam int unsigned N_CH    = 4;
  localparam int unsigned CH_BITS = 4;
  localparam int unsigned PL      = DL - CH_BITS;
  localparam logic [DL-1:0] IDLE_FRAME = {4'hF, 60'h0};

  logic          clk;
  logic          rst_n;
  logic [DL-1:0] spi_data_in;
  logic          spi_data_ready;
  logic          spi_cs;
  logic [DL-1:0] spi_data_out;
  logic          busy;
  logic [7:0]    bad_ch_cnt;

  spi_frame_arbiter_if #(.N_CH(N_CH), .PL(PL)) bus ();

  spi_frame_arbiter #(
    .DATA_LENGTH(DL), .N_CH(N_CH), .CH_BITS(CH_BITS), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .spi_data_in(spi_data_in), .spi_data_ready(spi_data_ready), .spi_cs(spi_cs),
    .spi_data_out(spi_data_out), .req(bus),
    .busy(busy), .bad_ch_cnt(bad_ch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int ch; logic [PL-1:0] data; } rx_exp_t;
  typedef struct { int ch; logic [DL-1:0] frame; } tx_exp_t;

  rx_exp_t rx_q[$];
  tx_exp_t grant_q[$];
  int      done_q[$];

  int checks = 0;
  int failures = 0;
  int ptr_m = 0;
  int bad_m = 0;
  logic [PL-1:0] last_rx_m = '0;
  int drv_grants = 0;
  int consumed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every presented pulse must match the head of its expectation queue.
  initial begin : monitor
    rx_exp_t e;
    tx_exp_t g;
    int      d;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (bus.rx_valid != '0) begin
          if (rx_q.size() == 0) chk("rx_unexpected", 64'(bus.rx_valid), 64'd0);
          else begin
            e = rx_q.pop_front();
            chk("rx_valid", 64'(bus.rx_valid), 64'(1 << e.ch));
            chk("rx_data", 64'(bus.rx_data), 64'(e.data));
          end
        end
        if (bus.tx_ready != '0) begin
          if (grant_q.size() == 0) chk("grant_unexpected", 64'(bus.tx_ready), 64'd0);
          else begin
            g = grant_q.pop_front();
            chk("tx_ready", 64'(bus.tx_ready), 64'(1 << g.ch));
            chk("grant_frame", spi_data_out, g.frame);
            chk("busy_at_grant", 64'(busy), 64'd1);
          end
        end
        if (bus.tx_done != '0) begin
          if (done_q.size() == 0) chk("done_unexpected", 64'(bus.tx_done), 64'd0);
          else begin
            d = done_q.pop_front();
            chk("tx_done", 64'(bus.tx_done), 64'(1 << d));
          end
        end
      end
    end
  end

  // Requester behaviour: drop a channel's request as soon as its grant is seen.
  task automatic tick();
    @(negedge clk);
    if (bus.tx_ready != '0) begin
      bus.tx_valid = bus.tx_valid & ~bus.tx_ready;
      drv_grants++;
    end
  endtask

  task automatic wait_grant();
    consumed++;
    for (int i = 0; i < 300; i++) begin
      if (drv_grants >= consumed) return;
      tick();
    end
    chk("grant_timeout", 64'(drv_grants), 64'(consumed));
  endtask

  function automatic logic [DL-1:0] rand_frame();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return {CH_BITS'($urandom_range(0, 15)), r[PL-1:0]};
  endfunction

  function automatic logic [PL-1:0] rand_pl();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[PL-1:0];
  endfunction

  // One SPI frame: check the presented frame, then raise frame-complete.
  task automatic send_frame(input logic [DL-1:0] f, input logic [DL-1:0] exp_out, input bit staged);
    int      hdr;
    rx_exp_t e;
    hdr = int'(f[DL-1 -: CH_BITS]);
    spi_cs = 1'b0;
    spi_data_in = f;
    repeat (3) tick();
    chk("data_out_in_frame", spi_data_out, exp_out);
    chk("busy_in_frame", 64'(busy), 64'(staged));
    if (hdr < N_CH) begin
      e.ch = hdr;
      e.data = f[PL-1:0];
      rx_q.push_back(e);
      last_rx_m = f[PL-1:0];
    end else if (hdr != 15) begin
      bad_m = (bad_m < 255) ? bad_m + 1 : 255;
    end
    spi_data_ready = 1'b1;
    repeat (6) tick();
    spi_data_ready = 1'b0;
    spi_cs = 1'b1;
    repeat (6) tick();
    chk("bad_ch_cnt", 64'(bad_ch_cnt), 64'(bad_m));
    chk("rx_data_hold", 64'(bus.rx_data), 64'(last_rx_m));
  endtask

  // Grant order from the rule: first requester at or after the pointer, wrapping.
  task automatic expect_grants(input logic [N_CH-1:0] mask, input logic [N_CH*PL-1:0] pl,
                               input bit with_done, output tx_exp_t seq[$]);
    logic [N_CH-1:0] m;
    tx_exp_t t;
    m = mask;
    seq.delete();
    while (m != '0) begin
      for (int k = 0; k < N_CH; k++) begin
        int c;
        c = (ptr_m + k) % N_CH;
        if (m[c]) begin
          t.ch = c;
          t.frame = {CH_BITS'(c), pl[c*PL +: PL]};
          seq.push_back(t);
          grant_q.push_back(t);
          if (with_done) done_q.push_back(c);
          m[c] = 1'b0;
          ptr_m = (c + 1) % N_CH;
          break;
        end
      end
    end
  endtask

  task automatic run_round(input logic [N_CH-1:0] mask, input logic [N_CH*PL-1:0] pl, input bit abort_first);
    tx_exp_t seq[$];
    expect_grants(mask, pl, 1'b1, seq);
    bus.tx_data = pl;
    bus.tx_valid = mask;
    foreach (seq[i]) begin
      wait_grant();
      if (abort_first && i == 0) begin
        spi_cs = 1'b0;
        spi_data_in = rand_frame();
        repeat (3) tick();
        spi_cs = 1'b1;
        repeat (4) tick();
        chk("abort_hold", spi_data_out, seq[i].frame);
        chk("abort_busy", 64'(busy), 64'd1);
      end
      send_frame(rand_frame(), seq[i].frame, 1'b1);
    end
    repeat (2) tick();
    chk("busy_after_round", 64'(busy), 64'd0);
    chk("idle_after_round", spi_data_out, IDLE_FRAME);
  endtask

  initial begin : driver
    logic [N_CH*PL-1:0] pl;
    logic [N_CH-1:0]    mask;
    tx_exp_t            seq[$];
    rst_n = 1'b0;
    spi_data_ready = 1'b0;
    spi_cs = 1'b1;
    spi_data_in = IDLE_FRAME;
    bus.tx_valid = '0;
    bus.tx_data = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_data_out", spi_data_out, IDLE_FRAME);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_bad", 64'(bad_ch_cnt), 64'd0);
    chk("rst_rx_data", 64'(bus.rx_data), 64'd0);
    chk("rst_pulses", 64'({bus.tx_ready, bus.tx_done, bus.rx_valid}), 64'd0);

    send_frame({4'h2, 60'h0ABC}, IDLE_FRAME, 1'b0);
    send_frame({4'h7, 60'h1234}, IDLE_FRAME, 1'b0);
    send_frame({4'hF, 60'h5678}, IDLE_FRAME, 1'b0);

    for (int i = 0; i < N_CH; i++) pl[i*PL +: PL] = PL'(i + 1);
    run_round(4'b1111, pl, 1'b0);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N_CH; i++) pl[i*PL +: PL] = rand_pl();
      run_round(4'b0010, pl, 1'b0);
    end

    for (int i = 0; i < N_CH; i++) pl[i*PL +: PL] = rand_pl();
    run_round(4'b1000, pl, 1'b1);

    // Reset while a frame is staged: no completion, pointer back to 0.
    for (int i = 0; i < N_CH; i++) pl[i*PL +: PL] = rand_pl();
    expect_grants(4'b0100, pl, 1'b0, seq);
    bus.tx_data = pl;
    bus.tx_valid = 4'b0100;
    wait_grant();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_data_out", spi_data_out, IDLE_FRAME);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_pulses", 64'({bus.tx_ready, bus.tx_done, bus.rx_valid}), 64'd0);
    bus.tx_valid = '0;
    ptr_m = 0;
    bad_m = 0;
    last_rx_m = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < N_CH; i++) pl[i*PL +: PL] = rand_pl();
    run_round(4'b1010, pl, 1'b0);

    for (int r = 0; r < 25; r++) begin
      if ($urandom_range(0, 2) == 0) send_frame(rand_frame(), IDLE_FRAME, 1'b0);
      mask = N_CH'($urandom_range(1, 15));
      for (int i = 0; i < N_CH; i++) pl[i*PL +: PL] = rand_pl();
      run_round(mask, pl, 1'b0);
    end

    repeat (10) tick();
    chk("rx_q_drained", 64'(rx_q.size()), 64'd0);
    chk("grant_q_drained", 64'(grant_q.size()), 64'd0);
    chk("done_q_drained", 64'(done_q.size()), 64'd0);
    chk("final_bad", 64'(bad_ch_cnt), 64'(bad_m));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule
